// File: rtl/slideshow_ctrl.sv
`default_nettype none
// ============================================================================
// slideshow_ctrl : slideshow sequencer (loader handshake, fades, dwell timer)
// Revision 1.0
// ============================================================================
module slideshow_ctrl #(
    parameter int NUM_IMG      = 4,
    parameter int DWELL_FRAMES = 300,
    parameter int IW           = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          btn_next,
    input  logic          btn_prev,
    input  logic          btn_pause,
    output logic          load_req,
    input  logic          load_ack,
    output logic [IW-1:0] load_idx,
    output logic [IW-1:0] disp_idx,
    output logic [3:0]    fade_level,
    output logic          paused
);

    // Dwell counter only spans 0..DWELL_FRAMES-1, so it can never wrap in SHOW
    localparam int                   c_DWELL_W    = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL_FRAMES - 1);
    localparam logic [IW-1:0]        c_LAST_IDX   = IW'(NUM_IMG - 1);
    localparam logic [3:0]           c_FADE_MAX   = 4'd15;

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_SHOW     = 2'd2,
        ST_FADE_OUT = 2'd3
    } state_t;

    state_t                 r_state,    w_state;
    logic [IW-1:0]          r_target,   w_target;
    logic                   r_load_req, w_load_req;
    logic [IW-1:0]          r_disp,     w_disp;
    logic [3:0]             r_fade,     w_fade;
    logic [c_DWELL_W-1:0]   r_dwell,    w_dwell;
    logic                   r_paused,   w_paused;
    logic [IW-1:0]          w_inc_idx;
    logic [IW-1:0]          w_dec_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_LOAD;
            r_target   <= '0;
            r_load_req <= 1'b0;
            r_disp     <= '0;
            r_fade     <= 4'd0;
            r_dwell    <= '0;
            r_paused   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_target   <= w_target;
            r_load_req <= w_load_req;
            r_disp     <= w_disp;
            r_fade     <= w_fade;
            r_dwell    <= w_dwell;
            r_paused   <= w_paused;
        end
    end

    always_comb begin
        w_inc_idx  = (r_disp == c_LAST_IDX) ? '0 : r_disp + IW'(1);
        w_dec_idx  = (r_disp == '0) ? c_LAST_IDX : r_disp - IW'(1);

        w_state    = r_state;
        w_target   = r_target;
        w_load_req = r_load_req;
        w_disp     = r_disp;
        w_fade     = r_fade;
        w_dwell    = r_dwell;
        w_paused   = r_paused ^ btn_pause;

        case (r_state)
            ST_LOAD: begin
                // Request is raised one edge after entry; acks seen before that are dropped
                if (!r_load_req) begin
                    w_load_req = 1'b1;
                end else if (load_ack) begin
                    w_load_req = 1'b0;
                    w_disp     = r_target;
                    w_fade     = 4'd0;
                    w_state    = ST_FADE_IN;
                end
            end
            ST_FADE_IN: begin
                if (frame_start && (r_fade != c_FADE_MAX)) begin
                    w_fade = r_fade + 4'd1;
                    if (r_fade == (c_FADE_MAX - 4'd1)) begin
                        w_state = ST_SHOW;
                        w_dwell = '0;
                    end
                end
            end
            ST_SHOW: begin
                if (btn_next) begin
                    w_target = w_inc_idx;
                    w_state  = ST_FADE_OUT;
                end else if (btn_prev) begin
                    w_target = w_dec_idx;
                    w_state  = ST_FADE_OUT;
                end else if (frame_start && !r_paused) begin
                    if (r_dwell == c_DWELL_LAST) begin
                        w_target = w_inc_idx;
                        w_state  = ST_FADE_OUT;
                    end else begin
                        w_dwell = r_dwell + 1'b1;
                    end
                end
            end
            ST_FADE_OUT: begin
                if (frame_start && (r_fade != 4'd0)) begin
                    w_fade = r_fade - 4'd1;
                    if (r_fade == 4'd1) begin
                        w_state = ST_LOAD;
                    end
                end
            end
            default: begin
                w_state = ST_LOAD;
            end
        endcase
    end

    assign load_req   = r_load_req;
    assign load_idx   = r_target;
    assign disp_idx   = r_disp;
    assign fade_level = r_fade;
    assign paused     = r_paused;

endmodule
`default_nettype wire
